// File: rtl/nvram_x2212_ctrl.sv
// Host-side sequencer for the 256x4 X2212 NVRAM: turns one-cycle read/write/store/recall
// requests into timed pin sequences, with an automatic recall after reset.
module nvram_x2212_ctrl #(
    parameter int ACC_CYC = 2,
    parameter int WR_CYC  = 2,
    parameter int RCL_CYC = 4,
    parameter int STO_CYC = 16,
    parameter int CW      = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req,
    input  logic [1:0] op,
    input  logic [7:0] addr,
    input  logic [3:0] wdata,
    output logic [3:0] rdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] nv_a,
    output logic [3:0] nv_i,
    input  logic [3:0] nv_o,
    output logic       nv_ce_n,
    output logic       nv_rw_n,
    output logic       nv_recall_n,
    output logic       nv_update
);
    typedef enum logic [2:0] {
        S_PWRUP_RCL, S_IDLE, S_READ, S_WRITE, S_SETTLE, S_STORE, S_RECALL
    } state_t;

    localparam logic [CW-1:0] ACC_LD = CW'(ACC_CYC - 1);
    localparam logic [CW-1:0] WR_LD  = CW'(WR_CYC - 1);
    localparam logic [CW-1:0] RCL_LD = CW'(RCL_CYC - 1);
    localparam logic [CW-1:0] STO_LD = CW'(STO_CYC - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic [3:0]    rdata_q, rdata_d, nv_i_q, nv_i_d;
    logic [7:0]    nv_a_q, nv_a_d;
    logic          ce_n_q, ce_n_d, rw_n_q, rw_n_d, recall_n_q, recall_n_d, update_q, update_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        rdata_d    = rdata_q;
        nv_a_d     = nv_a_q;
        nv_i_d     = nv_i_q;
        ce_n_d     = 1'b1;
        rw_n_d     = 1'b1;
        recall_n_d = 1'b1;
        update_d   = 1'b0;
        case (state_q)
            S_PWRUP_RCL, S_RECALL: begin
                // recall_n still high in PWRUP_RCL means the first cycle out of reset
                if (state_q == S_PWRUP_RCL && recall_n_q) begin
                    recall_n_d = 1'b0;
                    cnt_d      = RCL_LD;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = (state_q == S_RECALL);
                end else begin
                    recall_n_d = 1'b0;
                end
            end
            S_IDLE: begin
                busy_d = 1'b0;
                if (req) begin
                    busy_d = 1'b1;
                    nv_a_d = addr;
                    nv_i_d = wdata;
                    case (op)
                        2'b00: begin state_d = S_READ;   ce_n_d = 1'b0; cnt_d = ACC_LD; end
                        2'b01: begin state_d = S_WRITE;  ce_n_d = 1'b0; rw_n_d = 1'b0; cnt_d = WR_LD; end
                        2'b10: begin state_d = S_STORE;  update_d = 1'b1; cnt_d = STO_LD; end
                        default: begin state_d = S_RECALL; recall_n_d = 1'b0; cnt_d = RCL_LD; end
                    endcase
                end
            end
            S_READ: begin
                if (cnt_q == '0) begin
                    rdata_d = nv_o;
                    state_d = S_SETTLE;
                end else begin
                    ce_n_d = 1'b0;
                end
            end
            S_WRITE: begin
                if (cnt_q == '0) begin
                    state_d = S_SETTLE;
                end else begin
                    ce_n_d = 1'b0;
                    rw_n_d = 1'b0;
                end
            end
            S_SETTLE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            S_STORE: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    update_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_PWRUP_RCL;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            rdata_q    <= '0;
            nv_a_q     <= '0;
            nv_i_q     <= '0;
            ce_n_q     <= 1'b1;
            rw_n_q     <= 1'b1;
            recall_n_q <= 1'b1;
            update_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            nv_a_q     <= nv_a_d;
            nv_i_q     <= nv_i_d;
            ce_n_q     <= ce_n_d;
            rw_n_q     <= rw_n_d;
            recall_n_q <= recall_n_d;
            update_q   <= update_d;
        end
    end

    assign rdata       = rdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign nv_a        = nv_a_q;
    assign nv_i        = nv_i_q;
    assign nv_ce_n     = ce_n_q;
    assign nv_rw_n     = rw_n_q;
    assign nv_recall_n = recall_n_q;
    assign nv_update   = update_q;
endmodule

// File: tb/tb_nvram_x2212_ctrl.sv
// Directed bench for nvram_x2212_ctrl with a small behavioural X2212 (RAM + EEPROM shadow).
module tb_nvram_x2212_ctrl;
    logic       clk, reset_n, req;
    logic [1:0] op;
    logic [7:0] addr;
    logic [3:0] wdata, rdata;
    logic       busy, done;
    logic [7:0] nv_a;
    logic [3:0] nv_i, nv_o;
    logic       nv_ce_n, nv_rw_n, nv_recall_n, nv_update;

    int total = 0;
    int bad   = 0;
    int viol  = 0;

    logic [3:0] ram [256];
    logic [3:0] ee  [256];

    nvram_x2212_ctrl dut (
        .clk(clk), .reset_n(reset_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy), .done(done), .nv_a(nv_a), .nv_i(nv_i), .nv_o(nv_o),
        .nv_ce_n(nv_ce_n), .nv_rw_n(nv_rw_n), .nv_recall_n(nv_recall_n), .nv_update(nv_update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign nv_o = (!nv_ce_n && nv_rw_n) ? ram[nv_a] : 4'h0;

    // X2212 model: EEPROM preset to F, RAM starts at 0 so the power-up recall is visible.
    initial begin
        for (int k = 0; k < 256; k++) begin
            ee[k]  = 4'hF;
            ram[k] = 4'h0;
        end
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (!nv_rw_n && nv_ce_n) viol++;
                if (nv_update && !nv_recall_n) viol++;
                if ((nv_update || !nv_recall_n) && !nv_ce_n) viol++;
            end
            if (!nv_recall_n) for (int k = 0; k < 256; k++) ram[k] = ee[k];
            if (nv_update) for (int k = 0; k < 256; k++) ee[k] = ram[k];
            if (!nv_ce_n && !nv_rw_n) ram[nv_a] = nv_i;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pwrup(output int steps, output int rcl, output int dn);
        steps = 0; rcl = 0; dn = 0;
        reset_n = 1'b1;
        do begin
            step();
            steps++;
            if (!nv_recall_n) rcl++;
            if (done) dn++;
        end while (busy && steps < 40);
    endtask

    task automatic do_op(input logic [1:0] o, input logic [7:0] a, input logic [3:0] d,
                         input bit noise, output int lat, output int ce_lo, output int rw_lo,
                         output int upd_hi, output int rcl_lo, output int unstable);
        ce_lo = 0; rw_lo = 0; upd_hi = 0; rcl_lo = 0; unstable = 0;
        req = 1'b1; op = o; addr = a; wdata = d;
        step();
        lat = 1;
        if (noise) begin
            op = 2'b01; addr = 8'hAA; wdata = 4'hE;
        end else begin
            req = 1'b0;
        end
        while (!done && lat < 60) begin
            if (!nv_ce_n) ce_lo++;
            if (!nv_rw_n) rw_lo++;
            if (nv_update) upd_hi++;
            if (!nv_recall_n) rcl_lo++;
            if (!nv_ce_n && (nv_a !== a || nv_i !== d)) unstable++;
            step();
            lat++;
        end
        req = 1'b0;
    endtask

    int s, r, dn, lat, ce, rw, up, rc, us;

    initial begin
        reset_n = 1'b1; req = 1'b0; op = 2'b00; addr = 8'h00; wdata = 4'h0;
        #2 reset_n = 1'b0;
        step(); step();
        chk("rst_pins", 32'({nv_ce_n, nv_rw_n, nv_recall_n, nv_update}), 32'b1110);
        chk("rst_busy_done", 32'({busy, done}), 32'b10);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_a_i", 32'({nv_a, nv_i}), 32'h000);

        pwrup(s, r, dn);
        chk("pwrup_busy_cycles", s, 5);
        chk("pwrup_rcl_low", r, 4);
        chk("pwrup_no_done", dn, 0);

        do_op(2'b00, 8'h55, 4'h0, 1'b0, lat, ce, rw, up, rc, us);
        chk("rd55_lat", lat, 4);
        chk("rd55_data", 32'(rdata), 32'hF);

        do_op(2'b01, 8'h3C, 4'hA, 1'b0, lat, ce, rw, up, rc, us);
        chk("wr3c_lat", lat, 4);
        chk("wr3c_ce_low", ce, 2);
        chk("wr3c_rw_low", rw, 2);
        chk("wr3c_stable", us, 0);
        do_op(2'b00, 8'h3C, 4'h0, 1'b0, lat, ce, rw, up, rc, us);
        chk("rd3c_lat", lat, 4);
        chk("rd3c_ce_rw", ce * 10 + rw, 20);
        chk("rd3c_data", 32'(rdata), 32'hA);

        do_op(2'b01, 8'h00, 4'h5, 1'b1, lat, ce, rw, up, rc, us);
        chk("b2b_wr00_lat", lat, 4);
        chk("b2b_wr00_stable", us, 0);
        do_op(2'b01, 8'hFF, 4'h3, 1'b1, lat, ce, rw, up, rc, us);
        chk("b2b_wrff_lat", lat, 4);
        chk("b2b_wrff_stable", us, 0);
        step();
        chk("b2b_idle_after", 32'(busy), 32'h0);
        do_op(2'b00, 8'h00, 4'h0, 1'b0, lat, ce, rw, up, rc, us);
        chk("rd00_data", 32'(rdata), 32'h5);
        do_op(2'b00, 8'hAA, 4'h0, 1'b0, lat, ce, rw, up, rc, us);
        chk("rdaa_untouched", 32'(rdata), 32'hF);
        do_op(2'b00, 8'hFF, 4'h0, 1'b0, lat, ce, rw, up, rc, us);
        chk("rdff_data", 32'(rdata), 32'h3);

        do_op(2'b10, 8'h00, 4'h0, 1'b1, lat, ce, rw, up, rc, us);
        chk("sto_lat", lat, 17);
        chk("sto_update_high", up, 16);
        chk("sto_ce_low", ce, 0);
        chk("sto_rdata_kept", 32'(rdata), 32'h3);
        chk("sto_ee_3c", 32'(ee[8'h3C]), 32'hA);

        do_op(2'b01, 8'h10, 4'h7, 1'b0, lat, ce, rw, up, rc, us);
        chk("wr10_lat", lat, 4);
        do_op(2'b11, 8'h00, 4'h0, 1'b0, lat, ce, rw, up, rc, us);
        chk("rcl_lat", lat, 5);
        chk("rcl_low", rc, 4);
        chk("rcl_rdata_kept", 32'(rdata), 32'h3);
        do_op(2'b00, 8'h10, 4'h0, 1'b0, lat, ce, rw, up, rc, us);
        chk("rd10_restored", 32'(rdata), 32'hF);

        req = 1'b1; op = 2'b01; addr = 8'h20; wdata = 4'h9;
        step();
        req = 1'b0;
        step();
        chk("midwr_ce_low", 32'({nv_ce_n, nv_rw_n}), 32'b00);
        reset_n = 1'b0;
        #1;
        chk("midwr_rst_pins", 32'({nv_ce_n, nv_rw_n, nv_recall_n, nv_update}), 32'b1110);
        chk("midwr_rst_rdata", 32'(rdata), 32'h0);
        chk("midwr_rst_busy", 32'(busy), 32'h1);
        step();
        pwrup(s, r, dn);
        chk("rep_pwrup_cycles", s, 5);
        chk("rep_pwrup_rcl", r, 4);
        chk("rep_pwrup_no_done", dn, 0);
        do_op(2'b00, 8'h20, 4'h0, 1'b0, lat, ce, rw, up, rc, us);
        chk("rd20_after_rst", 32'(rdata), 32'hF);

        chk("pin_protocol", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nvram_x2212_ctrl.md
Name: nvram_x2212_ctrl

Overview:
- Initiator-side sequencer for the 256x4 X2212 NVRAM. It converts single-cycle host requests (read, write, store, recall) into correctly timed X2212 pin sequences.
- It issues an automatic recall after reset, so RAM contents are restored from EEPROM before the host is serviced.
- It sits between the CPU address decode and the nvram_x2212 instance.

Parameters:
- ACC_CYC, 2, cycles ce_n held low on a read before data is sampled (>=1)
- WR_CYC, 2, cycles ce_n and rw_n held low on a write (>=1)
- RCL_CYC, 4, cycles recall_n held low
- STO_CYC, 16, cycles update held high for an EEPROM store
- CW, 8, width of the internal cycle counter; each *_CYC value must be < 2^CW

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req  in  1  one-cycle request strobe, sampled only when busy=0
- op  in  2  request type: 00 read, 01 write, 10 store, 11 recall
- addr  in  8  host address
- wdata  in  4  host write data
- rdata  out  4  read data, valid from the done cycle until the next read completes
- busy  out  1  high whenever the FSM is not in IDLE
- done  out  1  one-cycle pulse when an operation finishes
- nv_a  out  8  to X2212 a
- nv_i  out  4  to X2212 i
- nv_o  in  4  from X2212 o
- nv_ce_n  out  1  to X2212 ce_n
- nv_rw_n  out  1  to X2212 rw_n
- nv_recall_n  out  1  to X2212 recall_n
- nv_update  out  1  to X2212 update (store)

Behaviour:
- All outputs are registered.
- Reset values (asynchronous on reset_n low):
  - state=PWRUP_RCL; busy=1, done=0, rdata=0
  - nv_a=0, nv_i=0, nv_ce_n=1, nv_rw_n=1, nv_recall_n=1, nv_update=0
  - counter=0
- States: PWRUP_RCL, IDLE, READ, WRITE, SETTLE, STORE, RECALL.
- Entry into a timed state loads the counter with its *_CYC-1. The state exits on the cycle the counter equals 0.
- PWRUP_RCL: entered on the first clk edge after reset_n is released.
  - nv_recall_n=0 for RCL_CYC cycles, then IDLE.
  - No done pulse is generated.
- IDLE: busy=0. On req=1:
  - addr and wdata are captured into nv_a and nv_i.
  - The next state is chosen by op. busy rises on the following cycle.
  - req with busy=1 is ignored; there is no queueing.
- READ: nv_ce_n=0, nv_rw_n=1 for ACC_CYC cycles.
  - In the last cycle, rdata<=nv_o.
  - Next is SETTLE.
- WRITE: nv_ce_n=0, nv_rw_n=0 for WR_CYC cycles; nv_a and nv_i are held stable throughout.
  - Next is SETTLE.
- SETTLE: exactly one cycle with nv_ce_n=1, nv_rw_n=1 (address/data hold time).
  - Then IDLE, with done=1 in the IDLE-entry cycle.
- STORE: nv_update=1 for STO_CYC cycles; nv_ce_n stays 1.
  - Then IDLE with done pulse.
- RECALL: identical pin sequence to PWRUP_RCL, but ends with a done pulse.
- nv_rw_n may only be low while nv_ce_n is low.
  - nv_rw_n rises in the same cycle as nv_ce_n, never after it.
  - nv_update and nv_recall_n=0 are never asserted together, and never together with nv_ce_n=0.
- Latencies from the req cycle to the done pulse:
  - read/write: 1+*_CYC+1 cycles
  - store: 1+STO_CYC
  - recall: 1+RCL_CYC
- rdata is unchanged by write, store and recall operations.
- reset_n asserted mid-operation:
  - All pins return to inactive immediately, so a write or store is truncated.
  - A full power-up recall follows the release of reset_n.
- Counter has no wrap: the counter is only loaded on state entry and decremented to 0, never below.

Test Plan:
- Reset release with the X2212 model preset to 4'hF everywhere -> nv_recall_n low for exactly 4 cycles, busy=1 for 5 cycles, no done pulse, and the first accepted req follows.
- Write addr=8'h3C wdata=4'hA, then read addr=8'h3C -> nv_ce_n and nv_rw_n low for 2 cycles with nv_a=3C and nv_i=A stable, done 4 cycles after req; read returns rdata=4'hA.
- Back-to-back: write 8'h00=4'h5 then 8'hFF=4'h3, with req re-asserted every cycle while busy -> exactly 2 operations occur; reads return 5 and 3; no pulse where nv_rw_n is low while nv_ce_n is high.
- Store op -> nv_update high for 16 cycles, nv_ce_n=1 throughout, done at cycle 17; a req during the store is ignored.
- Recall op after a write of 8'h10=4'h7 -> nv_recall_n low 4 cycles, done pulse at cycle 5; rdata retains its previous read value.
- reset_n pulsed low in the second cycle of a write -> nv_ce_n and nv_rw_n go to 1 asynchronously and rdata=0; the power-up recall sequence repeats after release.
